// File: rtl/vend_ctrl_param_if.sv
// Signal bundle between the front-panel conditioner, vend_ctrl_param and the
// dispenser/coin-return drivers. "slave" is the controller side.
interface vend_ctrl_param_if #(
  parameter int ITEM_W = 3,
  parameter int AMT_W  = 2,
  parameter int CENT_W = 10
);
  logic              i_cancel;
  logic              i_cont;
  logic [ITEM_W-1:0] i_item_sel;
  logic [AMT_W-1:0]  i_amt_sel;
  logic              i_dime;
  logic              i_quater;
  logic              i_dollar;
  logic [2:0]        o_state;
  logic [CENT_W-1:0] o_collected;
  logic [CENT_W-1:0] o_change;
  logic [ITEM_W-1:0] o_item;
  logic [AMT_W-1:0]  o_amt;
  logic [ITEM_W-1:0] o_delivery;
  logic [AMT_W-1:0]  o_vend_qty;
  logic              o_sold_out;
  logic              o_coin_rej;
  logic              o_timeout;

  modport master (
    output i_cancel, i_cont, i_item_sel, i_amt_sel, i_dime, i_quater, i_dollar,
    input  o_state, o_collected, o_change, o_item, o_amt, o_delivery,
           o_vend_qty, o_sold_out, o_coin_rej, o_timeout
  );

  modport slave (
    input  i_cancel, i_cont, i_item_sel, i_amt_sel, i_dime, i_quater, i_dollar,
    output o_state, o_collected, o_change, o_item, o_amt, o_delivery,
           o_vend_qty, o_sold_out, o_coin_rej, o_timeout
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: item/quantity selection, coin credit,
// per-item stock, vend with change, cancel refund and PAY inactivity timeout.
module vend_ctrl_param #(
  parameter int ITEM_W     = 3,
  parameter int AMT_W      = 2,
  parameter int CENT_W     = 10,
  parameter int BASE_PRICE = 50,
  parameter int PRICE_STEP = 25,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5,
  parameter int TIMEOUT    = 64
) (
  input logic              clk,
  input logic              rst_n,
  vend_ctrl_param_if.slave bus
);
  localparam int N_ITEMS = 2**ITEM_W;
  localparam int COST_W  = CENT_W + AMT_W;
  localparam int CMP_W   = (STOCK_W > AMT_W) ? STOCK_W : AMT_W;
  localparam int CNT_W   = $clog2(TIMEOUT) + 1;
  localparam int SUM_W   = CENT_W + 8;
  localparam longint MAX_CENT  = (longint'(1) << CENT_W) - 1;
  localparam longint MAX_PRICE = longint'(BASE_PRICE) + longint'(N_ITEMS - 2) * longint'(PRICE_STEP);
  localparam longint MAX_COST  = MAX_PRICE * ((longint'(1) << AMT_W) - 1);

  generate
    if (MAX_COST > MAX_CENT) begin : g_cost_range_check
      $error("vend_ctrl_param: most expensive order does not fit in CENT_W bits");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_QTY  = 3'd1,
    ST_PAY  = 3'd2,
    ST_VEND = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t             r_state, w_state_next;
  logic [CENT_W-1:0]  r_collected, w_collected_next;
  logic [CENT_W-1:0]  r_change, w_change_next;
  logic [ITEM_W-1:0]  r_item, w_item_next;
  logic [AMT_W-1:0]   r_amt, w_amt_next;
  logic [ITEM_W-1:0]  r_delivery, w_delivery_next;
  logic [AMT_W-1:0]   r_vend_qty, w_vend_qty_next;
  logic               r_sold_out, w_sold_out_next;
  logic               r_coin_rej, w_coin_rej_next;
  logic               r_timeout, w_timeout_next;
  logic [COST_W-1:0]  r_cost, w_cost_next;
  logic [CNT_W-1:0]   r_idle_cnt, w_idle_cnt_next;

  logic r_prev_cancel, r_prev_cont, r_prev_dime, r_prev_quater, r_prev_dollar;
  logic w_cancel_ev, w_cont_ev, w_dime_ev, w_quater_ev, w_dollar_ev;

  assign w_cancel_ev = bus.i_cancel & ~r_prev_cancel;
  assign w_cont_ev   = bus.i_cont   & ~r_prev_cont;
  assign w_dime_ev   = bus.i_dime   & ~r_prev_dime;
  assign w_quater_ev = bus.i_quater & ~r_prev_quater;
  assign w_dollar_ev = bus.i_dollar & ~r_prev_dollar;

  // Price lookup, one constant entry per item code (entry 0 is "no item").
  logic [CENT_W-1:0] w_price_tbl [N_ITEMS];
  assign w_price_tbl[0] = '0;
  for (genvar gi = 1; gi < N_ITEMS; gi++) begin : g_price
    assign w_price_tbl[gi] = CENT_W'(BASE_PRICE + (gi - 1) * PRICE_STEP);
  end

  // Stock counters; only the vended item decrements, and only in VEND.
  logic [STOCK_W-1:0] w_stock [N_ITEMS];
  for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_stock
    logic [STOCK_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= STOCK_W'(STOCK_INIT);
      end else if (r_state == ST_VEND && r_item == ITEM_W'(gi)) begin
        r_cnt <= r_cnt - STOCK_W'(r_amt);
      end
    end
    assign w_stock[gi] = r_cnt;
  end

  // Coin events of one cycle are summed and accepted or rejected as a whole.
  logic [SUM_W-1:0]  w_coin_sum, w_coin_total;
  logic              w_coin_any, w_coin_open, w_coin_acc;
  logic [CENT_W-1:0] w_credit;
  logic [COST_W-1:0] w_cost_calc;
  logic              w_qty_ok;

  assign w_coin_sum   = (w_dime_ev   ? SUM_W'(10)  : '0)
                      + (w_quater_ev ? SUM_W'(25)  : '0)
                      + (w_dollar_ev ? SUM_W'(100) : '0);
  assign w_coin_any   = w_dime_ev | w_quater_ev | w_dollar_ev;
  assign w_coin_open  = (r_state == ST_IDLE) || (r_state == ST_QTY) || (r_state == ST_PAY);
  assign w_coin_total = SUM_W'(r_collected) + w_coin_sum;
  assign w_coin_acc   = w_coin_any && w_coin_open && (w_coin_total <= SUM_W'(MAX_CENT));
  assign w_credit     = w_coin_acc ? w_coin_total[CENT_W-1:0] : r_collected;
  assign w_cost_calc  = COST_W'(w_price_tbl[r_item]) * COST_W'(bus.i_amt_sel);
  assign w_qty_ok     = CMP_W'(bus.i_amt_sel) <= CMP_W'(w_stock[r_item]);

  always_comb begin
    w_state_next     = r_state;
    w_collected_next = w_credit;
    w_change_next    = r_change;
    w_item_next      = r_item;
    w_amt_next       = r_amt;
    w_delivery_next  = '0;
    w_vend_qty_next  = '0;
    w_sold_out_next  = 1'b0;
    w_coin_rej_next  = w_coin_any && !w_coin_acc;
    w_timeout_next   = 1'b0;
    w_cost_next      = r_cost;
    w_idle_cnt_next  = r_idle_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_cancel_ev) begin
          w_change_next    = w_credit;
          w_collected_next = '0;
          w_state_next     = ST_HOLD;
        end else if (bus.i_item_sel != '0) begin
          if (w_stock[bus.i_item_sel] != '0) begin
            w_item_next  = bus.i_item_sel;
            w_state_next = ST_QTY;
          end else begin
            w_sold_out_next = 1'b1;
          end
        end
      end
      ST_QTY: begin
        if (w_cancel_ev) begin
          w_change_next    = w_credit;
          w_collected_next = '0;
          w_state_next     = ST_HOLD;
        end else if (bus.i_amt_sel != '0) begin
          if (w_qty_ok) begin
            w_amt_next      = bus.i_amt_sel;
            w_cost_next     = w_cost_calc;
            w_idle_cnt_next = '0;
            w_state_next    = ST_PAY;
          end else begin
            w_sold_out_next = 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (w_cancel_ev) begin
          w_change_next    = w_credit;
          w_collected_next = '0;
          w_state_next     = ST_HOLD;
        end else if (COST_W'(w_credit) >= r_cost) begin
          w_state_next = ST_VEND;
        end else if (w_coin_acc) begin
          w_idle_cnt_next = '0;
        end else if (r_idle_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout_next   = 1'b1;
          w_change_next    = w_credit;
          w_collected_next = '0;
          w_state_next     = ST_HOLD;
        end else begin
          w_idle_cnt_next = r_idle_cnt + CNT_W'(1);
        end
      end
      ST_VEND: begin
        // Coins are refused here, so w_credit equals r_collected.
        w_delivery_next  = r_item;
        w_vend_qty_next  = r_amt;
        w_change_next    = CENT_W'(COST_W'(r_collected) - r_cost);
        w_collected_next = '0;
        w_state_next     = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_cont_ev) begin
          w_change_next = '0;
          w_item_next   = '0;
          w_amt_next    = '0;
          w_state_next  = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_collected   <= '0;
      r_change      <= '0;
      r_item        <= '0;
      r_amt         <= '0;
      r_delivery    <= '0;
      r_vend_qty    <= '0;
      r_sold_out    <= 1'b0;
      r_coin_rej    <= 1'b0;
      r_timeout     <= 1'b0;
      r_cost        <= '0;
      r_idle_cnt    <= '0;
      r_prev_cancel <= 1'b0;
      r_prev_cont   <= 1'b0;
      r_prev_dime   <= 1'b0;
      r_prev_quater <= 1'b0;
      r_prev_dollar <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_collected   <= w_collected_next;
      r_change      <= w_change_next;
      r_item        <= w_item_next;
      r_amt         <= w_amt_next;
      r_delivery    <= w_delivery_next;
      r_vend_qty    <= w_vend_qty_next;
      r_sold_out    <= w_sold_out_next;
      r_coin_rej    <= w_coin_rej_next;
      r_timeout     <= w_timeout_next;
      r_cost        <= w_cost_next;
      r_idle_cnt    <= w_idle_cnt_next;
      r_prev_cancel <= bus.i_cancel;
      r_prev_cont   <= bus.i_cont;
      r_prev_dime   <= bus.i_dime;
      r_prev_quater <= bus.i_quater;
      r_prev_dollar <= bus.i_dollar;
    end
  end

  assign bus.o_state     = r_state;
  assign bus.o_collected = r_collected;
  assign bus.o_change    = r_change;
  assign bus.o_item      = r_item;
  assign bus.o_amt       = r_amt;
  assign bus.o_delivery  = r_delivery;
  assign bus.o_vend_qty  = r_vend_qty;
  assign bus.o_sold_out  = r_sold_out;
  assign bus.o_coin_rej  = r_coin_rej;
  assign bus.o_timeout   = r_timeout;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: directed scenarios with literal expectations,
// then random stimulus, all outputs compared each cycle to a behavioural model.
module tb_vend_ctrl_param;
  localparam int ITEM_W = 3, AMT_W = 2, CENT_W = 10;
  localparam int BASE = 50, STEP = 25, SINIT = 5, TMO = 64;
  localparam int MAXC = (1 << CENT_W) - 1;

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   total, bad;

  vend_ctrl_param_if #(.ITEM_W(ITEM_W), .AMT_W(AMT_W), .CENT_W(CENT_W)) bus ();

  vend_ctrl_param #(
    .ITEM_W(ITEM_W), .AMT_W(AMT_W), .CENT_W(CENT_W), .BASE_PRICE(BASE),
    .PRICE_STEP(STEP), .STOCK_W(4), .STOCK_INIT(SINIT), .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: spec states by number, timeout by elapsed-cycle count.
  int m_state, m_coll, m_chg, m_item, m_amt, m_deliv, m_vq, m_cost;
  int m_sold, m_rej, m_tmo, m_cyc, m_last;
  int m_stock [8];
  bit p_c, p_k, p_d, p_q, p_D;
  bit ev_c, ev_k, ev_d, ev_q, ev_D, acc;
  int sum;

  function automatic int price(int k);
    return BASE + (k - 1) * STEP;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_coll = 0; m_chg = 0; m_item = 0; m_amt = 0; m_cost = 0;
      m_deliv = 0; m_vq = 0; m_sold = 0; m_rej = 0; m_tmo = 0;
      m_cyc = 0; m_last = 0;
      for (int k = 0; k < 8; k++) m_stock[k] = SINIT;
      p_c = 0; p_k = 0; p_d = 0; p_q = 0; p_D = 0;
    end else begin
      ev_c = bus.i_cancel && !p_c; ev_k = bus.i_cont && !p_k;
      ev_d = bus.i_dime && !p_d;   ev_q = bus.i_quater && !p_q;
      ev_D = bus.i_dollar && !p_D;
      p_c = bus.i_cancel; p_k = bus.i_cont; p_d = bus.i_dime;
      p_q = bus.i_quater; p_D = bus.i_dollar;
      m_deliv = 0; m_vq = 0; m_sold = 0; m_rej = 0; m_tmo = 0; acc = 0;
      sum = (ev_d ? 10 : 0) + (ev_q ? 25 : 0) + (ev_D ? 100 : 0);
      if (sum > 0) begin
        if (m_state <= 2 && m_coll + sum <= MAXC) begin
          m_coll += sum; acc = 1;
        end else m_rej = 1;
      end
      if (m_state <= 2 && ev_c) begin
        m_chg = m_coll; m_coll = 0; m_state = 4;
      end else if (m_state == 0) begin
        if (bus.i_item_sel != 0) begin
          if (m_stock[bus.i_item_sel] > 0) begin m_item = bus.i_item_sel; m_state = 1; end
          else m_sold = 1;
        end
      end else if (m_state == 1) begin
        if (bus.i_amt_sel != 0) begin
          if (bus.i_amt_sel <= m_stock[m_item]) begin
            m_amt = bus.i_amt_sel; m_cost = price(m_item) * m_amt;
            m_state = 2; m_last = m_cyc;
          end else m_sold = 1;
        end
      end else if (m_state == 2) begin
        if (m_coll >= m_cost) m_state = 3;
        else if (acc) m_last = m_cyc;
        else if (m_cyc - m_last >= TMO) begin
          m_tmo = 1; m_chg = m_coll; m_coll = 0; m_state = 4;
        end
      end else if (m_state == 3) begin
        m_deliv = m_item; m_vq = m_amt; m_stock[m_item] -= m_amt;
        m_chg = m_coll - m_cost; m_coll = 0; m_state = 4;
      end else if (m_state == 4) begin
        if (ev_k) begin m_chg = 0; m_item = 0; m_amt = 0; m_state = 0; end
      end
      m_cyc++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("state", bus.o_state, m_state);
      check("collected", bus.o_collected, m_coll);
      check("change", bus.o_change, m_chg);
      check("item", bus.o_item, m_item);
      check("amt", bus.o_amt, m_amt);
      check("delivery", bus.o_delivery, m_deliv);
      check("vend_qty", bus.o_vend_qty, m_vq);
      check("sold_out", bus.o_sold_out, m_sold);
      check("coin_rej", bus.o_coin_rej, m_rej);
      check("timeout", bus.o_timeout, m_tmo);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic zero_inputs();
    bus.i_cancel = 0; bus.i_cont = 0; bus.i_item_sel = '0; bus.i_amt_sel = '0;
    bus.i_dime = 0; bus.i_quater = 0; bus.i_dollar = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  task automatic pulse_cancel();
    bus.i_cancel = 1; cyc(1); bus.i_cancel = 0; cyc(1);
  endtask

  task automatic pulse_cont();
    bus.i_cont = 1; cyc(1); bus.i_cont = 0; cyc(1);
  endtask

  task automatic dollar_gap();
    bus.i_dollar = 1; cyc(1); bus.i_dollar = 0; cyc(1);
  endtask

  task automatic select(input int it, input int qt);
    bus.i_item_sel = ITEM_W'(it); cyc(1); bus.i_item_sel = '0;
    bus.i_amt_sel = AMT_W'(qt); cyc(1); bus.i_amt_sel = '0;
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 0;
    zero_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk_en = 1;
    check("reset_state", bus.o_state, 0);
    check("reset_collected", bus.o_collected, 0);
    check("reset_change", bus.o_change, 0);

    // Coins in IDLE, cancel refund, cont back to IDLE.
    bus.i_dime = 1; cyc(1); check("dime_10", bus.o_collected, 10);
    bus.i_dime = 0; bus.i_quater = 1; cyc(1); check("quater_35", bus.o_collected, 35);
    bus.i_quater = 0; bus.i_cancel = 1; cyc(1);
    check("cancel_state", bus.o_state, 4);
    check("cancel_change", bus.o_change, 35);
    check("cancel_collected", bus.o_collected, 0);
    bus.i_cancel = 0; bus.i_cont = 1; cyc(1);
    check("cont_state", bus.o_state, 0);
    check("cont_change", bus.o_change, 0);
    bus.i_cont = 0; cyc(1);

    // Item 4 qty 2 (cost 250), three dollars.
    select(4, 2);
    check("pay_state", bus.o_state, 2);
    dollar_gap(); dollar_gap();
    bus.i_dollar = 1; cyc(1);
    check("vend_state", bus.o_state, 3);
    check("vend_collected", bus.o_collected, 300);
    bus.i_dollar = 0; cyc(1);
    check("delivery_4", bus.o_delivery, 4);
    check("vend_qty_2", bus.o_vend_qty, 2);
    check("change_50", bus.o_change, 50);
    check("model_stock4", m_stock[4], 3);
    pulse_cont();

    // Item 1: buy 3, then over-ask, then exhaust stock.
    select(1, 3);
    dollar_gap(); dollar_gap();
    check("item1_change", bus.o_change, 50);
    pulse_cont();
    bus.i_item_sel = 1; cyc(1); bus.i_item_sel = 0;
    bus.i_amt_sel = 3; cyc(1);
    check("qty_sold_out", bus.o_sold_out, 1);
    check("qty_stay", bus.o_state, 1);
    bus.i_amt_sel = 2; cyc(1); bus.i_amt_sel = 0;
    check("qty2_pay", bus.o_state, 2);
    dollar_gap(); cyc(1);
    check("item1_done", bus.o_state, 4);
    pulse_cont();
    bus.i_item_sel = 1; cyc(1); bus.i_item_sel = 0;
    check("idle_sold_out", bus.o_sold_out, 1);
    check("idle_stay", bus.o_state, 0);
    cyc(1);

    // Timeout 64 cycles after the last accepted coin.
    select(2, 1);
    bus.i_dime = 1; cyc(1); bus.i_dime = 0;
    cyc(63);
    check("pre_timeout", bus.o_timeout, 0);
    check("pre_timeout_state", bus.o_state, 2);
    cyc(1);
    check("timeout_pulse", bus.o_timeout, 1);
    check("timeout_state", bus.o_state, 4);
    check("timeout_change", bus.o_change, 10);
    pulse_cont();

    // Credit saturation at 1023.
    for (int i = 0; i < 10; i++) dollar_gap();
    check("ten_dollars", bus.o_collected, 1000);
    bus.i_dollar = 1; cyc(1);
    check("overflow_rej", bus.o_coin_rej, 1);
    check("overflow_hold", bus.o_collected, 1000);
    bus.i_dollar = 0; bus.i_dime = 1; cyc(1);
    check("dime_1010", bus.o_collected, 1010);
    bus.i_dime = 0; cyc(1);
    pulse_cancel(); pulse_cont();

    // Simultaneous coins, cancel with coin, held coin level.
    bus.i_dollar = 1; bus.i_quater = 1; cyc(1);
    check("sum_125", bus.o_collected, 125);
    bus.i_dollar = 0; bus.i_quater = 0; cyc(1);
    pulse_cancel(); pulse_cont();
    bus.i_quater = 1; cyc(1); bus.i_quater = 0; cyc(1);
    bus.i_quater = 1; cyc(1); bus.i_quater = 0; cyc(1);
    bus.i_cancel = 1; bus.i_dime = 1; cyc(1);
    check("cancel_dime_change", bus.o_change, 60);
    bus.i_cancel = 0; bus.i_dime = 0; cyc(1);
    pulse_cont();
    bus.i_dollar = 1; cyc(5); bus.i_dollar = 0; cyc(1);
    check("held_dollar", bus.o_collected, 100);
    pulse_cancel(); pulse_cont();

    // Random traffic; quiet stretches let PAY time out; one mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      bit quiet;
      if (i == 2000) do_reset();
      quiet = ((i / 300) % 3) == 2;
      bus.i_cancel   = !quiet && ($urandom_range(0, 23) == 0);
      bus.i_cont     = ($urandom_range(0, 3) == 0);
      bus.i_dime     = !quiet && ($urandom_range(0, 4) == 0);
      bus.i_quater   = !quiet && ($urandom_range(0, 4) == 0);
      bus.i_dollar   = !quiet && ($urandom_range(0, 4) == 0);
      bus.i_item_sel = ($urandom_range(0, 3) == 0) ? ITEM_W'($urandom_range(0, 7)) : '0;
      bus.i_amt_sel  = ($urandom_range(0, 3) == 0) ? AMT_W'($urandom_range(0, 3)) : '0;
      cyc(1);
    end
    zero_inputs();
    cyc(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
